ysyx_22040895_csr_unit: RTL and testbench
=========================================

# ysyx_22040895_csr_unit

Machine-mode CSR unit for the ysyx_22040895 RV64 core, addressed by the standard 12-bit CSR number. Executes CSRRW/CSRRS/CSRRC read-modify-write, performs trap entry and `mret` state sequencing, and supplies the fetch redirect target, including vectored interrupts. Raises a registered machine-timer interrupt request, and optionally keeps `mcycle`/`minstret`. Sits beside the execute stage and is driven by the decode/exception logic.

## Interface
- XLEN, 64, data width of every CSR and data port
- MTVEC_RESET, 0, reset value of `mtvec`
- HARTID, 0, value returned by `mhartid`

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- csr_valid_i  in  1  a CSR instruction is present this cycle
- csr_op_i  in  2  01 RW, 10 RS, 11 RC, 00 read-only/no-op
- csr_addr_i  in  12  CSR number
- csr_wdata_i  in  XLEN  rs1 value or zero-extended uimm
- csr_rdata_o  out  XLEN  old value of the addressed CSR
- csr_illegal_o  out  1  unmapped CSR, or write to a read-only CSR
- trap_i  in  1  take an exception or interrupt this cycle
- trap_cause_i  in  XLEN  `mcause` value; bit XLEN-1 set for an interrupt
- trap_pc_i  in  XLEN  PC to save in `mepc`
- mret_i  in  1  `mret` retires this cycle
- instret_i  in  1  one instruction retires this cycle
- irq_timer_i  in  1  raw machine-timer level
- redirect_o  out  1  fetch must jump to `redirect_pc_o`
- redirect_pc_o  out  XLEN  trap vector or `mepc`
- irq_pending_o  out  1  an enabled timer interrupt is pending

## Operation
**CSR map:**
- `mstatus` 0x300: only MIE[3] and MPIE[7] are writable; MPP[12:11] reads 2'b11; all other bits read 0.
- `mie` 0x304: only MTIE[7] is writable.
- `mtvec` 0x305: bit 1 reads 0; bit 0 is MODE (1 = vectored).
- `mscratch` 0x340.
- `mepc` 0x341: bit 0 is forced to 0.
- `mcause` 0x342.
- `mip` 0x344: read-only; MTIP[7] is the registered `irq_timer_i`.
- `mhartid` 0xF14: read-only, returns HARTID.
- `mcycle` 0xB00 and `minstret` 0xB02 exist only under the macro.

**CSR instructions:**
- Read is combinational: `csr_rdata_o` = current value when `csr_valid_i`, otherwise 0.
- New value: RW → wdata; RS → old | wdata; RC → old & ~wdata. It is written at the next posedge.
- RS/RC with `csr_wdata_i`==0, and op 00, do not write. They are therefore legal on read-only CSRs.
- `csr_illegal_o` (combinational, gated by `csr_valid_i`) is set for:
  - an unmapped address;
  - a write on addr[11:10]==2'b11.
- When `csr_illegal_o` is set, no state changes and `csr_rdata_o`=0.

**Trap entry (`trap_i`):**
- `mepc` ← `trap_pc_i` & ~1; `mcause` ← `trap_cause_i`; MPIE ← MIE; MIE ← 0.
- `redirect_o`=1.
- `redirect_pc_o` = {mtvec[XLEN-1:2],2'b00}, plus 4×cause[5:0] when MODE=1 and cause bit XLEN-1 is set.

**`mret`:**
- MIE ← MPIE; MPIE ← 1.
- `redirect_o`=1; `redirect_pc_o` = `mepc`.

**Priority:** `trap_i` > `mret_i` > CSR write. A lower-priority write in the same cycle is dropped entirely.

**Interrupt request:** `irq_pending_o` = MIE & MTIE & MTIP.

**Reset values:**
- All writable CSRs are 0, except `mtvec` = MTVEC_RESET.
- MTIP is 0.
- While `rst` is high, all outputs are 0 and every input event is ignored.

## Timing
- `csr_rdata_o`, `csr_illegal_o`, `redirect_o` and `redirect_pc_o` are combinational, same cycle.
- CSR updates are visible the cycle after the write edge. Back-to-back accesses need no bypass: the second one reads the new value.
- `irq_timer_i` → MTIP takes 1 cycle, so `irq_pending_o` rises 1 cycle after the input.
- A trap clears MIE at the edge, so `irq_pending_o` drops the following cycle.
- A trap and an `mret` in the same cycle: the trap wins and `redirect_pc_o` is the vector.
- Reset asserted in the middle of a sequence clears all state on that edge, including the counters.

## Configuration
- `YSYX_22040895_CSR_COUNTER_EN` defined:
  - `mcycle` increments every non-reset cycle; `minstret` increments when `instret_i` is high.
  - Both wrap from 2^XLEN−1 to 0.
  - A CSR write to either counter overrides that cycle's increment.
- Undefined: 0xB00/0xB02 are unmapped and raise `csr_illegal_o`; no counter flops exist.

## Test plan
- Reset, then read `mtvec` with op 00 → MTVEC_RESET; read `mstatus` → 0x1800; read `mhartid` → HARTID.
- CSRRW `mscratch`=0xA5, then CSRRS 0x0F, then CSRRC 0xA0 → reads return 0, 0xA5, 0xAF; the final value is 0x0F.
- Set MIE, then trap with cause 0x8000000000000007, pc 0x80000103, mtvec=0x80001001 → redirect 0x8000101C, `mepc`=0x80000102, MIE=0, MPIE=1. Then `mret` → redirect 0x80000102, MIE=1.
- Set MIE=1 and MTIE=1, pulse `irq_timer_i` → `irq_pending_o`=1 exactly one cycle later. Then assert `trap_i` together with a CSRRW to `mscratch` → `mscratch` is unchanged.
- CSRRW on `mip`, and on address 0x7C0 → `csr_illegal_o`=1, no state change. CSRRS `mip` with wdata 0 → legal.
- With the macro defined:
  - write `mcycle`=2^64−1 → reads 0 one cycle later;
  - `instret_i` high for 3 cycles → `minstret`=3.

Source files
------------

// File: rtl/ysyx_22040895_csr_unit.sv
// ysyx_22040895_csr_unit: machine-mode CSR file for the RV64 core.
// Handles CSRRW/CSRRS/CSRRC, trap entry, mret, fetch redirect and the
// timer interrupt request. Optional mcycle/minstret counters are built
// when YSYX_22040895_CSR_COUNTER_EN is defined.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   csr_valid_i/op_i/addr_i     CSR instruction (op 01 RW, 10 RS, 11 RC)
//   csr_wdata_i                 rs1 value or zero-extended uimm
//   csr_rdata_o                 old value of the addressed CSR
//   csr_illegal_o               unmapped CSR or write to a read-only CSR
//   trap_i/trap_cause_i/pc_i    trap entry request, cause and faulting PC
//   mret_i                      mret retires this cycle
//   instret_i                   one instruction retires this cycle
//   irq_timer_i                 raw machine-timer level
//   redirect_o/redirect_pc_o    fetch redirect and its target
//   irq_pending_o               enabled timer interrupt pending
module ysyx_22040895_csr_unit #(
    parameter int              XLEN        = 64,
    parameter logic [XLEN-1:0] MTVEC_RESET = '0,
    parameter logic [XLEN-1:0] HARTID      = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            csr_valid_i,
    input  logic [1:0]      csr_op_i,
    input  logic [11:0]     csr_addr_i,
    input  logic [XLEN-1:0] csr_wdata_i,
    output logic [XLEN-1:0] csr_rdata_o,
    output logic            csr_illegal_o,
    input  logic            trap_i,
    input  logic [XLEN-1:0] trap_cause_i,
    input  logic [XLEN-1:0] trap_pc_i,
    input  logic            mret_i,
    input  logic            instret_i,
    input  logic            irq_timer_i,
    output logic            redirect_o,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic            irq_pending_o
);

    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MIP      = 12'h344;
    localparam logic [11:0] A_MHARTID  = 12'hF14;
`ifdef YSYX_22040895_CSR_COUNTER_EN
    localparam logic [11:0] A_MCYCLE   = 12'hB00;
    localparam logic [11:0] A_MINSTRET = 12'hB02;
`endif

    localparam logic [XLEN-1:0] BIT0 = XLEN'(1);
    localparam logic [XLEN-1:0] BIT1 = XLEN'(2);

    logic            st_mie;
    logic            st_mpie;
    logic            mtie;
    logic            mtip;
    logic [XLEN-1:0] mtvec;
    logic [XLEN-1:0] mscratch;
    logic [XLEN-1:0] mepc;
    logic [XLEN-1:0] mcause;
`ifdef YSYX_22040895_CSR_COUNTER_EN
    logic [XLEN-1:0] mcycle;
    logic [XLEN-1:0] minstret;
`endif

    logic [XLEN-1:0] mstatus_val;
    logic [XLEN-1:0] mie_val;
    logic [XLEN-1:0] mip_val;
    logic [XLEN-1:0] old_val;
    logic [XLEN-1:0] new_val;
    logic [XLEN-1:0] vec_off;
    logic            mapped;
    logic            read_only;
    logic            wr_req;
    logic            illegal;
    logic            wr_en;

    always_comb begin
        mstatus_val        = '0;
        mstatus_val[12:11] = 2'b11;
        mstatus_val[7]     = st_mpie;
        mstatus_val[3]     = st_mie;
        mie_val            = '0;
        mie_val[7]         = mtie;
        mip_val            = '0;
        mip_val[7]         = mtip;
    end

    always_comb begin
        mapped    = 1'b1;
        read_only = 1'b0;
        old_val   = '0;
        case (csr_addr_i)
            A_MSTATUS:  old_val = mstatus_val;
            A_MIE:      old_val = mie_val;
            A_MTVEC:    old_val = mtvec & ~BIT1;
            A_MSCRATCH: old_val = mscratch;
            A_MEPC:     old_val = mepc;
            A_MCAUSE:   old_val = mcause;
            A_MIP: begin
                old_val   = mip_val;
                read_only = 1'b1;
            end
            A_MHARTID: begin
                old_val   = HARTID;
                read_only = 1'b1;
            end
`ifdef YSYX_22040895_CSR_COUNTER_EN
            A_MCYCLE:   old_val = mcycle;
            A_MINSTRET: old_val = minstret;
`endif
            default:    mapped = 1'b0;
        endcase
    end

    // RS/RC with a zero operand is a pure read and never writes.
    assign wr_req = (csr_op_i == 2'b01) || (csr_op_i[1] && (|csr_wdata_i));

    assign illegal = csr_valid_i && !rst &&
                     (!mapped ||
                      (wr_req && (read_only || csr_addr_i[11:10] == 2'b11)));

    // Trap and mret both take precedence over a CSR write.
    assign wr_en = csr_valid_i && !rst && !illegal && wr_req &&
                   !trap_i && !mret_i;

    always_comb begin
        case (csr_op_i)
            2'b01:   new_val = csr_wdata_i;
            2'b10:   new_val = old_val | csr_wdata_i;
            2'b11:   new_val = old_val & ~csr_wdata_i;
            default: new_val = old_val;
        endcase
    end

    assign csr_illegal_o = illegal;
    assign csr_rdata_o   = (csr_valid_i && !rst && !illegal) ? old_val : '0;

    // Vectored mode offsets only interrupts, by 4 * cause[5:0].
    assign vec_off = (mtvec[0] && trap_cause_i[XLEN-1]) ?
                     {{(XLEN-8){1'b0}}, trap_cause_i[5:0], 2'b00} : '0;

    always_comb begin
        redirect_o    = 1'b0;
        redirect_pc_o = '0;
        if (!rst) begin
            if (trap_i) begin
                redirect_o    = 1'b1;
                redirect_pc_o = {mtvec[XLEN-1:2], 2'b00} + vec_off;
            end else if (mret_i) begin
                redirect_o    = 1'b1;
                redirect_pc_o = mepc;
            end
        end
    end

    assign irq_pending_o = !rst && st_mie && mtie && mtip;

    always_ff @(posedge clk) begin
        if (rst) begin
            st_mie   <= 1'b0;
            st_mpie  <= 1'b0;
            mtie     <= 1'b0;
            mtvec    <= MTVEC_RESET;
            mscratch <= '0;
            mepc     <= '0;
            mcause   <= '0;
        end else if (trap_i) begin
            mepc    <= trap_pc_i & ~BIT0;
            mcause  <= trap_cause_i;
            st_mpie <= st_mie;
            st_mie  <= 1'b0;
        end else if (mret_i) begin
            st_mie  <= st_mpie;
            st_mpie <= 1'b1;
        end else if (wr_en) begin
            case (csr_addr_i)
                A_MSTATUS: begin
                    st_mie  <= new_val[3];
                    st_mpie <= new_val[7];
                end
                A_MIE:      mtie     <= new_val[7];
                A_MTVEC:    mtvec    <= new_val & ~BIT1;
                A_MSCRATCH: mscratch <= new_val;
                A_MEPC:     mepc     <= new_val & ~BIT0;
                A_MCAUSE:   mcause   <= new_val;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) mtip <= 1'b0;
        else     mtip <= irq_timer_i;
    end

`ifdef YSYX_22040895_CSR_COUNTER_EN
    // A CSR write replaces that cycle's increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcycle   <= '0;
            minstret <= '0;
        end else begin
            if (wr_en && csr_addr_i == A_MCYCLE)
                mcycle <= new_val;
            else
                mcycle <= mcycle + XLEN'(1);
            if (wr_en && csr_addr_i == A_MINSTRET)
                minstret <= new_val;
            else if (instret_i)
                minstret <= minstret + XLEN'(1);
        end
    end
`endif

endmodule

// File: tb/tb_ysyx_22040895_csr_unit.sv
// tb_ysyx_22040895_csr_unit: directed self-checking bench for the
// machine-mode CSR unit (RV64, MTVEC_RESET = 0, HARTID = 0).
module tb_ysyx_22040895_csr_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        csr_valid;
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;
    logic [63:0] csr_wdata;
    logic [63:0] csr_rdata;
    logic        csr_illegal;
    logic        trap;
    logic [63:0] trap_cause;
    logic [63:0] trap_pc;
    logic        mret;
    logic        instret;
    logic        irq_timer;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        irq_pending;

    int tests = 0;
    int fails = 0;

    localparam logic [1:0] OP_RD = 2'b00;
    localparam logic [1:0] OP_RW = 2'b01;
    localparam logic [1:0] OP_RS = 2'b10;
    localparam logic [1:0] OP_RC = 2'b11;

    ysyx_22040895_csr_unit #(
        .XLEN(64),
        .MTVEC_RESET(64'h0),
        .HARTID(64'h0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .csr_valid_i(csr_valid),
        .csr_op_i(csr_op),
        .csr_addr_i(csr_addr),
        .csr_wdata_i(csr_wdata),
        .csr_rdata_o(csr_rdata),
        .csr_illegal_o(csr_illegal),
        .trap_i(trap),
        .trap_cause_i(trap_cause),
        .trap_pc_i(trap_pc),
        .mret_i(mret),
        .instret_i(instret),
        .irq_timer_i(irq_timer),
        .redirect_o(redirect),
        .redirect_pc_o(redirect_pc),
        .irq_pending_o(irq_pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs at the falling edge, settle 1 time unit.
    task automatic step(input logic v, input logic [1:0] op,
                        input logic [11:0] a, input logic [63:0] d);
        @(negedge clk);
        csr_valid = v;
        csr_op    = op;
        csr_addr  = a;
        csr_wdata = d;
        trap      = 1'b0;
        mret      = 1'b0;
        instret   = 1'b0;
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        csr_valid  = 1'b0;
        csr_op     = OP_RD;
        csr_addr   = '0;
        csr_wdata  = '0;
        trap       = 1'b0;
        trap_cause = '0;
        trap_pc    = '0;
        mret       = 1'b0;
        instret    = 1'b0;
        irq_timer  = 1'b0;

        // Reset: all inputs ignored, all outputs zero.
        step(1'b1, OP_RW, 12'h340, 64'hFF);
        trap      = 1'b1;
        irq_timer = 1'b1;
        #1;
        chk("rst_rdata", csr_rdata, 64'h0);
        chk("rst_redirect", {63'h0, redirect}, 64'h0);
        chk("rst_redirect_pc", redirect_pc, 64'h0);
        chk("rst_irq", {63'h0, irq_pending}, 64'h0);
        step(1'b1, OP_RW, 12'h340, 64'hFF);
        trap      = 1'b1;
        #1;
        rst       = 1'b0;
        irq_timer = 1'b0;

        step(1'b1, OP_RD, 12'h305, 64'h0);
        chk("mtvec_reset", csr_rdata, 64'h0);
        step(1'b1, OP_RD, 12'h300, 64'h0);
        chk("mstatus_reset", csr_rdata, 64'h1800);
        step(1'b1, OP_RD, 12'hF14, 64'h0);
        chk("mhartid", csr_rdata, 64'h0);
        chk("mhartid_legal", {63'h0, csr_illegal}, 64'h0);
        step(1'b1, OP_RD, 12'h340, 64'h0);
        chk("mscratch_reset", csr_rdata, 64'h0);
        step(1'b1, OP_RD, 12'h344, 64'h0);
        chk("mip_reset", csr_rdata, 64'h0);

        // Read-modify-write sequence on mscratch.
        step(1'b1, OP_RW, 12'h340, 64'hA5);
        chk("rw_old", csr_rdata, 64'h0);
        step(1'b1, OP_RS, 12'h340, 64'h0F);
        chk("rs_old", csr_rdata, 64'hA5);
        step(1'b1, OP_RC, 12'h340, 64'hA0);
        chk("rc_old", csr_rdata, 64'hAF);
        step(1'b1, OP_RD, 12'h340, 64'h0);
        chk("mscratch_final", csr_rdata, 64'h0F);
        step(1'b0, OP_RD, 12'h340, 64'h0);
        chk("rdata_gated", csr_rdata, 64'h0);

        // mepc bit 0 is forced low.
        step(1'b1, OP_RW, 12'h341, 64'h301);
        step(1'b1, OP_RD, 12'h341, 64'h0);
        chk("mepc_bit0", csr_rdata, 64'h300);

        // Trap entry with vectored mtvec.
        step(1'b1, OP_RW, 12'h300, 64'h8);
        chk("mstatus_old", csr_rdata, 64'h1800);
        step(1'b1, OP_RW, 12'h305, 64'h80001003);
        step(1'b1, OP_RD, 12'h305, 64'h0);
        chk("mtvec_bit1", csr_rdata, 64'h80001001);
        step(1'b0, OP_RD, 12'h0, 64'h0);
        trap       = 1'b1;
        trap_cause = 64'h8000000000000007;
        trap_pc    = 64'h80000103;
        #1;
        chk("trap_redirect", {63'h0, redirect}, 64'h1);
        chk("trap_vec", redirect_pc, 64'h8000101C);
        step(1'b1, OP_RD, 12'h341, 64'h0);
        chk("trap_mepc", csr_rdata, 64'h80000102);
        step(1'b1, OP_RD, 12'h342, 64'h0);
        chk("trap_mcause", csr_rdata, 64'h8000000000000007);
        step(1'b1, OP_RD, 12'h300, 64'h0);
        chk("trap_mstatus", csr_rdata, 64'h1880);
        step(1'b0, OP_RD, 12'h0, 64'h0);
        mret = 1'b1;
        #1;
        chk("mret_redirect", {63'h0, redirect}, 64'h1);
        chk("mret_pc", redirect_pc, 64'h80000102);
        step(1'b1, OP_RD, 12'h300, 64'h0);
        chk("mret_mstatus", csr_rdata, 64'h1888);

        // Exception with trap and mret together: trap wins, base vector.
        step(1'b0, OP_RD, 12'h0, 64'h0);
        trap       = 1'b1;
        mret       = 1'b1;
        trap_cause = 64'h2;
        trap_pc    = 64'h100;
        #1;
        chk("trap_mret_pc", redirect_pc, 64'h80001000);
        step(1'b1, OP_RD, 12'h300, 64'h0);
        chk("exc_mstatus", csr_rdata, 64'h1880);
        step(1'b0, OP_RD, 12'h0, 64'h0);
        mret = 1'b1;
        #1;
        chk("mret2_pc", redirect_pc, 64'h100);

        // Timer interrupt path.
        step(1'b1, OP_RW, 12'h304, 64'hFFFF);
        step(1'b1, OP_RD, 12'h304, 64'h0);
        chk("mie_mask", csr_rdata, 64'h80);
        step(1'b1, OP_RD, 12'h300, 64'h0);
        chk("mie_set", csr_rdata, 64'h1888);
        step(1'b0, OP_RD, 12'h0, 64'h0);
        irq_timer = 1'b1;
        #1;
        chk("irq_not_yet", {63'h0, irq_pending}, 64'h0);
        step(1'b1, OP_RD, 12'h344, 64'h0);
        chk("irq_pending", {63'h0, irq_pending}, 64'h1);
        chk("mip_mtip", csr_rdata, 64'h80);
        step(1'b1, OP_RW, 12'h340, 64'h55);
        trap       = 1'b1;
        trap_cause = 64'h8000000000000007;
        trap_pc    = 64'h200;
        #1;
        chk("trap_irq_still", {63'h0, irq_pending}, 64'h1);
        step(1'b1, OP_RD, 12'h340, 64'h0);
        irq_timer = 1'b0;
        chk("irq_dropped", {63'h0, irq_pending}, 64'h0);
        chk("trap_drops_wr", csr_rdata, 64'h0F);

        // mret also drops a same-cycle write.
        step(1'b1, OP_RW, 12'h340, 64'h77);
        mret = 1'b1;
        #1;
        step(1'b1, OP_RD, 12'h340, 64'h0);
        chk("mret_drops_wr", csr_rdata, 64'h0F);

        // Illegal accesses.
        step(1'b1, OP_RW, 12'h344, 64'h80);
        chk("mip_rw_ill", {63'h0, csr_illegal}, 64'h1);
        chk("mip_rw_rdata", csr_rdata, 64'h0);
        step(1'b1, OP_RW, 12'h7C0, 64'h1);
        chk("unmapped_ill", {63'h0, csr_illegal}, 64'h1);
        step(1'b1, OP_RS, 12'hF14, 64'h1);
        chk("hartid_rs_ill", {63'h0, csr_illegal}, 64'h1);
        step(1'b1, OP_RC, 12'hF14, 64'h0);
        chk("hartid_rc0_ok", {63'h0, csr_illegal}, 64'h0);
        step(1'b1, OP_RS, 12'h344, 64'h0);
        chk("mip_rs0_ok", {63'h0, csr_illegal}, 64'h0);
        step(1'b0, OP_RW, 12'h7C0, 64'h1);
        chk("ill_gated", {63'h0, csr_illegal}, 64'h0);

`ifdef YSYX_22040895_CSR_COUNTER_EN
        step(1'b1, OP_RW, 12'hB00, 64'hFFFF_FFFF_FFFF_FFFF);
        step(1'b1, OP_RD, 12'hB00, 64'h0);
        chk("mcycle_max", csr_rdata, 64'hFFFF_FFFF_FFFF_FFFF);
        step(1'b1, OP_RD, 12'hB00, 64'h0);
        chk("mcycle_wrap", csr_rdata, 64'h0);
        step(1'b1, OP_RW, 12'hB02, 64'h0);
        step(1'b0, OP_RD, 12'h0, 64'h0);
        instret = 1'b1;
        step(1'b0, OP_RD, 12'h0, 64'h0);
        instret = 1'b1;
        step(1'b0, OP_RD, 12'h0, 64'h0);
        instret = 1'b1;
        step(1'b1, OP_RD, 12'hB02, 64'h0);
        chk("minstret_3", csr_rdata, 64'h3);
`else
        step(1'b1, OP_RD, 12'hB00, 64'h0);
        chk("mcycle_ill", {63'h0, csr_illegal}, 64'h1);
        step(1'b1, OP_RD, 12'hB02, 64'h0);
        chk("minstret_ill", {63'h0, csr_illegal}, 64'h1);
`endif

        // Reset mid-sequence clears state.
        step(1'b0, OP_RD, 12'h0, 64'h0);
        rst = 1'b1;
        #1;
        step(1'b1, OP_RD, 12'h340, 64'h0);
        rst = 1'b0;
        #1;
        chk("rst2_mscratch", csr_rdata, 64'h0);
        step(1'b1, OP_RD, 12'h305, 64'h0);
        chk("rst2_mtvec", csr_rdata, 64'h0);
        step(1'b1, OP_RD, 12'h300, 64'h0);
        chk("rst2_mstatus", csr_rdata, 64'h1800);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
